// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester, vector-LSU and data-memory signals of the dmem port arbiter
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic [ADDR_W-1:0] core_addr;
  logic [3:0]        core_we;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              con_req;
  logic [ADDR_W-1:0] con_addr;
  logic [3:0]        con_we;
  logic [DATA_W-1:0] con_wdata;
  logic              con_gnt;
  logic              con_rvalid;
  logic [DATA_W-1:0] con_rdata;

  logic              vec_req;
  logic              vec_store;
  logic [ADDR_W-1:0] vec_addr;
  logic [ADDR_W-1:0] vec_stride;
  logic [DATA_W-1:0] vec_wdata_0, vec_wdata_1, vec_wdata_2, vec_wdata_3;
  logic              vec_gnt;
  logic              vec_busy;
  logic              vec_done;
  logic [DATA_W-1:0] vec_rdata_0, vec_rdata_1, vec_rdata_2, vec_rdata_3;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and the memory macro sit on the master side.
  modport master (
    output core_req, core_addr, core_we, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output con_req, con_addr, con_we, con_wdata,
    input  con_gnt, con_rvalid, con_rdata,
    output vec_req, vec_store, vec_addr, vec_stride,
    output vec_wdata_0, vec_wdata_1, vec_wdata_2, vec_wdata_3,
    input  vec_gnt, vec_busy, vec_done,
    input  vec_rdata_0, vec_rdata_1, vec_rdata_2, vec_rdata_3,
    input  mem_en, mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  core_req, core_addr, core_we, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  con_req, con_addr, con_we, con_wdata,
    output con_gnt, con_rvalid, con_rdata,
    input  vec_req, vec_store, vec_addr, vec_stride,
    input  vec_wdata_0, vec_wdata_1, vec_wdata_2, vec_wdata_3,
    output vec_gnt, vec_busy, vec_done,
    output vec_rdata_0, vec_rdata_1, vec_rdata_2, vec_rdata_3,
    output mem_en, mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin data-memory port arbiter: core, mcont, 4-beat vector bursts
// Optional stall_cnt output enabled by DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VBURST = 2'd1;
  localparam logic [1:0] S_VDRAIN = 2'd2;

  logic [1:0]        state;
  logic [1:0]        ptr;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] burst_addr;
  logic [ADDR_W-1:0] stride;
  logic              store;
  logic [DATA_W-1:0] wd_1, wd_2, wd_3;
  logic [DATA_W-1:0] lane_wdata;
  logic              cap_valid;
  logic [1:0]        cap_lane;
  logic              core_rd_q, con_rd_q, done_q;
  logic [DATA_W-1:0] rd_0, rd_1, rd_2, rd_3;

  logic core_gnt, con_gnt, vec_gnt, vec_elig;

  assign vec_elig = bus.vec_req && (state == S_IDLE);

  // ptr names the requester with top priority: 0 core, 1 con, 2 vec.
  always_comb begin
    core_gnt = 1'b0;
    con_gnt  = 1'b0;
    vec_gnt  = 1'b0;
    if (!rst && state != S_VBURST) begin
      case (ptr)
        2'd0: begin
          if (bus.core_req)     core_gnt = 1'b1;
          else if (bus.con_req) con_gnt  = 1'b1;
          else if (vec_elig)    vec_gnt  = 1'b1;
        end
        2'd1: begin
          if (bus.con_req)       con_gnt  = 1'b1;
          else if (vec_elig)     vec_gnt  = 1'b1;
          else if (bus.core_req) core_gnt = 1'b1;
        end
        default: begin
          if (vec_elig)          vec_gnt  = 1'b1;
          else if (bus.core_req) core_gnt = 1'b1;
          else if (bus.con_req)  con_gnt  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    case (beat)
      2'd1:    lane_wdata = wd_1;
      2'd2:    lane_wdata = wd_2;
      default: lane_wdata = wd_3;
    endcase
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 4'h0;
    bus.mem_wdata = '0;
    if (core_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.core_addr;
      bus.mem_we    = bus.core_we;
      bus.mem_wdata = bus.core_wdata;
    end else if (con_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.con_addr;
      bus.mem_we    = bus.con_we;
      bus.mem_wdata = bus.con_wdata;
    end else if (vec_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.vec_addr;
      bus.mem_we    = bus.vec_store ? 4'hF : 4'h0;
      bus.mem_wdata = bus.vec_wdata_0;
    end else if (!rst && state == S_VBURST) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = burst_addr;
      bus.mem_we    = store ? 4'hF : 4'h0;
      bus.mem_wdata = lane_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= 2'd0;
      beat       <= 2'd0;
      burst_addr <= '0;
      stride     <= '0;
      store      <= 1'b0;
      wd_1       <= '0;
      wd_2       <= '0;
      wd_3       <= '0;
      cap_valid  <= 1'b0;
      cap_lane   <= 2'd0;
      core_rd_q  <= 1'b0;
      con_rd_q   <= 1'b0;
      done_q     <= 1'b0;
      rd_0       <= '0;
      rd_1       <= '0;
      rd_2       <= '0;
      rd_3       <= '0;
    end else begin
      core_rd_q <= core_gnt && (bus.core_we == 4'h0);
      con_rd_q  <= con_gnt && (bus.con_we == 4'h0);
      done_q    <= (state == S_VDRAIN);
      cap_valid <= 1'b0;
      if (core_gnt)     ptr <= 2'd1;
      else if (con_gnt) ptr <= 2'd2;
      else if (vec_gnt) ptr <= 2'd0;

      case (state)
        S_IDLE: begin
          if (vec_gnt) begin
            state      <= S_VBURST;
            beat       <= 2'd1;
            burst_addr <= bus.vec_addr + bus.vec_stride;
            stride     <= bus.vec_stride;
            store      <= bus.vec_store;
            wd_1       <= bus.vec_wdata_1;
            wd_2       <= bus.vec_wdata_2;
            wd_3       <= bus.vec_wdata_3;
            cap_valid  <= !bus.vec_store;
            cap_lane   <= 2'd0;
          end
        end
        S_VBURST: begin
          burst_addr <= burst_addr + stride;
          beat       <= beat + 2'd1;
          cap_valid  <= !store;
          cap_lane   <= beat;
          if (beat == 2'd3) state <= S_VDRAIN;
        end
        default: state <= S_IDLE;
      endcase

      // Lane data returns one cycle after its beat was issued.
      if (cap_valid) begin
        case (cap_lane)
          2'd0:    rd_0 <= bus.mem_rdata;
          2'd1:    rd_1 <= bus.mem_rdata;
          2'd2:    rd_2 <= bus.mem_rdata;
          default: rd_3 <= bus.mem_rdata;
        endcase
      end
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.con_gnt     = con_gnt;
  assign bus.vec_gnt     = vec_gnt;
  assign bus.core_rvalid = core_rd_q;
  assign bus.con_rvalid  = con_rd_q;
  assign bus.core_rdata  = core_rd_q ? bus.mem_rdata : '0;
  assign bus.con_rdata   = con_rd_q ? bus.mem_rdata : '0;
  assign bus.vec_busy    = !rst && (vec_gnt || state != S_IDLE);
  assign bus.vec_done    = done_q;
  assign bus.vec_rdata_0 = rd_0;
  assign bus.vec_rdata_1 = rd_1;
  assign bus.vec_rdata_2 = rd_2;
  assign bus.vec_rdata_3 = rd_3;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (((bus.core_req && !core_gnt) || (bus.con_req && !con_gnt))
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule
